// File: rtl/slink_pstate_req_sequencer_pkg.sv
// Shared definitions for the P-state request sequencer: FSM encodings,
// P-state select codes and the request priority encoder.
package slink_pstate_req_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      QUAL     = 3'd1,
      ENTER    = 3'd2,
      IN_PX    = 3'd3,
      EXIT     = 3'd4,
      COOLDOWN = 3'd5
   } seq_state_e;

   localparam logic [1:0] PX_SEL_P0 = 2'd0;
   localparam logic [1:0] PX_SEL_P1 = 2'd1;
   localparam logic [1:0] PX_SEL_P2 = 2'd2;
   localparam logic [1:0] PX_SEL_P3 = 2'd3;

   // Deepest requested state wins.
   function automatic logic [1:0] px_sel_encode(input logic p1, input logic p2, input logic p3);
      if (p3)      return PX_SEL_P3;
      else if (p2) return PX_SEL_P2;
      else if (p1) return PX_SEL_P1;
      else         return PX_SEL_P0;
   endfunction

endpackage

// File: rtl/slink_demet_reset_n.sv
// Single-bit synchronizer, STAGES flops deep, cleared by an active-low async reset.
module slink_demet_reset_n #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[STAGES-2:0], d};
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/slink_pstate_req_sequencer.sv
// Runs the Px entry/exit handshake with the link layer from synchronized
// P-state requests, with qualification, ack timeouts and a post-exit cooldown.
module slink_pstate_req_sequencer
   import slink_pstate_req_sequencer_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int TMO_W         = 8
) (
   input  logic             link_clk,
   input  logic             link_clk_reset_n,
   input  logic             enable,
   input  logic             p1_req,
   input  logic             p2_req,
   input  logic             p3_req,
   input  logic             wake_req,
   input  logic [TMO_W-1:0] swi_ack_timeout,
   input  logic [TMO_W-1:0] swi_cooldown,
   output logic             ll_px_req,
   output logic [1:0]       ll_px_sel,
   input  logic             ll_px_ack,
   output logic             ll_exit_req,
   input  logic             ll_exit_ack,
   output logic             in_px_state,
   output logic [1:0]       px_state_cur,
   output logic             timeout_err,
   input  logic             clear_err
);

   localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

   logic             p1_s, p2_s, p3_s, wake_s;
   logic [1:0]       sel;
   seq_state_e       state, state_d;
   logic [7:0]       stable_cnt, stable_cnt_d;
   logic [1:0]       cand, cand_d;
   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d, tmo_next;
   logic [TMO_W-1:0] cool_cnt, cool_cnt_d, cool_next;
   logic             tmo_fire, cool_done, tmo_hit;
   logic             ll_px_req_d, ll_exit_req_d, in_px_state_d, timeout_err_d;
   logic [1:0]       ll_px_sel_d, px_state_cur_d;

   slink_demet_reset_n #(.STAGES(SYNC_STAGES)) u_sync_p1   (.clk(link_clk), .rst_n(link_clk_reset_n), .d(p1_req),   .q(p1_s));
   slink_demet_reset_n #(.STAGES(SYNC_STAGES)) u_sync_p2   (.clk(link_clk), .rst_n(link_clk_reset_n), .d(p2_req),   .q(p2_s));
   slink_demet_reset_n #(.STAGES(SYNC_STAGES)) u_sync_p3   (.clk(link_clk), .rst_n(link_clk_reset_n), .d(p3_req),   .q(p3_s));
   slink_demet_reset_n #(.STAGES(SYNC_STAGES)) u_sync_wake (.clk(link_clk), .rst_n(link_clk_reset_n), .d(wake_req), .q(wake_s));

   assign sel = px_sel_encode(p1_s, p2_s, p3_s);

   // The timeout fires on the edge where the saturating count reaches the limit,
   // so a request is held for exactly swi_ack_timeout cycles without an ack.
   assign tmo_next  = (tmo_cnt == '1)  ? tmo_cnt  : tmo_cnt + TMO_W'(1);
   assign cool_next = (cool_cnt == '1) ? cool_cnt : cool_cnt + TMO_W'(1);
   assign tmo_fire  = (swi_ack_timeout != '0) && (tmo_next == swi_ack_timeout);
   assign cool_done = (cool_next >= swi_cooldown);

   always_comb begin
      state_d = state;
      case (state)
         IDLE:     if (enable && sel != PX_SEL_P0 && !wake_s) state_d = QUAL;
         QUAL:     if (!enable || wake_s || sel != cand)      state_d = IDLE;
                   else if (stable_cnt == STABLE_LAST)        state_d = ENTER;
         ENTER:    if (ll_px_ack)                             state_d = IN_PX;
                   else if (tmo_fire)                         state_d = COOLDOWN;
         IN_PX:    if (wake_s || !enable || sel == PX_SEL_P0) state_d = EXIT;
         EXIT:     if (ll_exit_ack)                           state_d = COOLDOWN;
         COOLDOWN: if (cool_done)                             state_d = IDLE;
         default:                                             state_d = IDLE;
      endcase
   end

   // Counters restart on every state change; outputs are derived from the
   // next state so that they can be registered without extra latency.
   always_comb begin
      stable_cnt_d = stable_cnt;
      cand_d       = cand;
      tmo_cnt_d    = tmo_cnt;
      cool_cnt_d   = cool_cnt;
      case (state)
         IDLE: begin
            stable_cnt_d = '0;
            cand_d       = sel;
         end
         QUAL:        stable_cnt_d = stable_cnt + 8'd1;
         ENTER, EXIT: tmo_cnt_d    = tmo_next;
         COOLDOWN:    cool_cnt_d   = cool_next;
         default:     ;
      endcase
      if (state_d != state) begin
         tmo_cnt_d  = '0;
         cool_cnt_d = '0;
      end

      tmo_hit        = tmo_fire && ((state == ENTER && !ll_px_ack) || (state == EXIT && !ll_exit_ack));
      ll_px_req_d    = (state_d == ENTER);
      ll_exit_req_d  = (state_d == EXIT);
      in_px_state_d  = (state_d inside {IN_PX, EXIT});
      ll_px_sel_d    = (state_d inside {ENTER, IN_PX, EXIT}) ? cand : PX_SEL_P0;
      px_state_cur_d = in_px_state_d ? cand : PX_SEL_P0;
      timeout_err_d  = tmo_hit | (timeout_err & ~clear_err);
   end

   always_ff @(posedge link_clk or negedge link_clk_reset_n) begin
      if (!link_clk_reset_n) begin
         state        <= IDLE;
         stable_cnt   <= '0;
         cand         <= PX_SEL_P0;
         tmo_cnt      <= '0;
         cool_cnt     <= '0;
         ll_px_req    <= 1'b0;
         ll_px_sel    <= PX_SEL_P0;
         ll_exit_req  <= 1'b0;
         in_px_state  <= 1'b0;
         px_state_cur <= PX_SEL_P0;
         timeout_err  <= 1'b0;
      end else begin
         state        <= state_d;
         stable_cnt   <= stable_cnt_d;
         cand         <= cand_d;
         tmo_cnt      <= tmo_cnt_d;
         cool_cnt     <= cool_cnt_d;
         ll_px_req    <= ll_px_req_d;
         ll_px_sel    <= ll_px_sel_d;
         ll_exit_req  <= ll_exit_req_d;
         in_px_state  <= in_px_state_d;
         px_state_cur <= px_state_cur_d;
         timeout_err  <= timeout_err_d;
      end
   end

endmodule
